max7219_driver: RTL

//  Consumes per-digit segment patterns from sseg_decoder instances (7-bit GFEDCBA, active-low)
//  and drives a MAX7219 LED controller over its 3-wire serial bus. After reset it sends the

---
 rtl/max7219_pkg.sv | 34 +++
 rtl/max7219_spi_tx.sv | 91 +++++++++
 rtl/max7219_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display driver: register map,
// driver FSM states and the segment-to-register data conversion.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT1    = 8'h02;
  localparam logic [7:0] REG_DIGIT2    = 8'h03;
  localparam logic [7:0] REG_DIGIT3    = 8'h04;
  localparam logic [7:0] REG_DIGIT4    = 8'h05;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DIGIT6    = 8'h07;
  localparam logic [7:0] REG_DIGIT7    = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  // Number of words in the power-up configuration sequence.
  localparam int INIT_WORDS = 5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2
  } drv_state_t;

  // seg is GFEDCBA, active-low. The chip wants active-high DP,A,B,C,D,E,F,G on D7..D0.
  function automatic logic [7:0] seg_to_max(input logic [6:0] seg, input logic dp);
    return {dp, ~seg[0], ~seg[1], ~seg[2], ~seg[3], ~seg[4], ~seg[5], ~seg[6]};
  endfunction

endpackage

// File: rtl/max7219_spi_tx.sv
// Serializes one 16-bit MAX7219 word, MSB first, followed by an idle gap
// with LOAD high. done pulses in the first cycle the serializer is free again.
module max7219_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        busy,
  output logic        done,
  output logic        din,
  output logic        sclk,
  output logic        cs_n
);

  localparam int            CW         = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(2 * CLK_DIV - 1);

  logic          r_busy;
  logic          r_done;
  logic          r_din;
  logic          r_sclk;
  logic          r_cs_n;
  logic          r_gap;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [14:0]   r_shift;

  // Phase down-counter drives sclk half-periods, bit count and the trailing gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_din   <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_gap   <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (start) begin
          r_busy  <= 1'b1;
          r_cs_n  <= 1'b0;
          r_sclk  <= 1'b0;
          r_din   <= word[15];
          r_shift <= word[14:0];
          r_bit   <= 4'd15;
          r_cnt   <= PHASE_LOAD;
          r_gap   <= 1'b0;
        end
      end else if (r_gap) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end else begin
          r_busy <= 1'b0;
          r_gap  <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end else if (!r_sclk) begin
        r_sclk <= 1'b1;
        r_cnt  <= PHASE_LOAD;
      end else if (r_bit == 4'd0) begin
        // Last high phase over: raise LOAD to latch the word and start the gap.
        r_sclk <= 1'b0;
        r_cs_n <= 1'b1;
        r_gap  <= 1'b1;
        r_cnt  <= GAP_LOAD;
      end else begin
        r_sclk  <= 1'b0;
        r_din   <= r_shift[14];
        r_shift <= {r_shift[13:0], 1'b0};
        r_bit   <= r_bit - 4'd1;
        r_cnt   <= PHASE_LOAD;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign din  = r_din;
  assign sclk = r_sclk;
  assign cs_n = r_cs_n;

endmodule

// File: rtl/max7219_driver.sv
// MAX7219 display driver: configures the chip after reset, then sends one
// full frame of digit registers per valid/ready handshake.
//
//  state    | meaning
//  ST_INIT  | sending the configuration words, index = next word
//  ST_IDLE  | ready=1, waiting for a frame
//  ST_FRAME | sending digit words from the latched frame, index = next digit
module max7219_driver
  import max7219_pkg::*;
#(
  parameter int         NUM_DIGITS = 8,
  parameter int         CLK_DIV    = 4,
  parameter logic [3:0] INTENSITY  = 4'h8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] segs,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    valid,
  output logic                    ready,
  output logic                    max_din,
  output logic                    max_sclk,
  output logic                    max_cs_n
);

  drv_state_t              r_state;
  drv_state_t              w_state_nxt;
  logic [3:0]              r_idx;
  logic [3:0]              w_idx_nxt;
  logic                    r_ready;
  logic [7*NUM_DIGITS-1:0] r_segs;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    w_start;
  logic                    w_latch;
  logic [15:0]             w_word;
  logic [15:0]             w_init_word;
  logic [15:0]             w_frame_word [8];
  logic                    w_busy;
  logic                    w_done;

  // Digit words are built from the latched frame so input changes mid-frame are ignored.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    if (gi < NUM_DIGITS) begin : g_used
      assign w_frame_word[gi] = {8'(REG_DIGIT0 + gi), seg_to_max(r_segs[7*gi +: 7], r_dp[gi])};
    end else begin : g_unused
      assign w_frame_word[gi] = 16'h0000;
    end
  end

  // Configuration sequence lookup.
  always_comb begin
    w_init_word = {REG_SHUTDOWN, 8'h01};
    case (r_idx)
      4'd0:    w_init_word = {REG_TEST, 8'h00};
      4'd1:    w_init_word = {REG_DECODE, 8'h00};
      4'd2:    w_init_word = {REG_SCANLIMIT, 8'(NUM_DIGITS - 1)};
      4'd3:    w_init_word = {REG_INTENSITY, 4'h0, INTENSITY};
      default: w_init_word = {REG_SHUTDOWN, 8'h01};
    endcase
  end

  // Next-state, word select and serializer start.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_latch     = 1'b0;
    w_word      = 16'h0000;
    case (r_state)
      ST_INIT: begin
        w_word = w_init_word;
        // Word 0 goes out straight after reset; later words follow each done pulse.
        if ((r_idx == 4'd0 && !w_busy) || w_done) begin
          if (r_idx == 4'(INIT_WORDS)) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 4'd0;
          end else begin
            w_start   = 1'b1;
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        // Digit 0 is launched from the live inputs so LOAD falls the cycle after the handshake.
        w_word = {REG_DIGIT0, seg_to_max(segs[6:0], dp[0])};
        if (valid && r_ready) begin
          w_start     = 1'b1;
          w_latch     = 1'b1;
          w_idx_nxt   = 4'd1;
          w_state_nxt = ST_FRAME;
        end
      end
      ST_FRAME: begin
        w_word = w_frame_word[r_idx[2:0]];
        if (w_done) begin
          if (r_idx == 4'(NUM_DIGITS)) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 4'd0;
          end else begin
            w_start   = 1'b1;
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  // State, index, registered ready and frame capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_idx   <= 4'd0;
      r_ready <= 1'b0;
      r_segs  <= '1;
      r_dp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      if (w_latch) begin
        r_segs <= segs;
        r_dp   <= dp;
      end
    end
  end

  max7219_spi_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_spi_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .word  (w_word),
    .busy  (w_busy),
    .done  (w_done),
    .din   (max_din),
    .sclk  (max_sclk),
    .cs_n  (max_cs_n)
  );

  assign ready = r_ready;

endmodule
